// File: rtl/multi_blink_pkg.sv
// multi_blink_pkg -- shared types and defaults for the multi-channel blinker.
//   mode_e     : per-channel LED mode (OFF, ON, BLINK, FLASH)
//   DEF_*      : default parameter values for multi_blink
package multi_blink_pkg;

  localparam int DEF_CBITS = 26;
  localparam int DEF_NCH   = 4;
  localparam int DEF_DIVW  = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_FLASH = 2'b11
  } mode_e;

endpackage

// File: rtl/blink_chan.sv
// blink_chan -- one LED channel: tick divider, phase toggle, wrap pulse, LED mux.
//   clk, rst   : clock, async active-high reset
//   tick_i     : prescaler tick (one cycle per prescaler wrap)
//   mode_i     : channel mode (mode_e encoding)
//   div_i      : divide value; phase toggles every div_i+1 ticks
//   led_o      : registered LED drive
//   wrap_o     : registered one-cycle divider-wrap pulse
module blink_chan
  import multi_blink_pkg::*;
#(
  parameter int DIVW = DEF_DIVW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_i,
  input  logic [1:0]      mode_i,
  input  logic [DIVW-1:0] div_i,
  output logic            led_o,
  output logic            wrap_o
);

  logic [DIVW-1:0] dcnt_q, dcnt_d;
  logic            phase_q, phase_d;
  logic            wrap_q, wrap_d;
  logic            led_q, led_d;

  always_comb begin
    dcnt_d  = dcnt_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (tick_i) begin
      // ">=" so that lowering div below the running count wraps at once
      // instead of counting all the way around the divider.
      if (dcnt_q >= div_i) begin
        dcnt_d  = '0;
        phase_d = ~phase_q;
        wrap_d  = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // LED follows the next-state phase/wrap so it changes on the same edge.
  always_comb begin
    led_d = 1'b0;
    case (mode_e'(mode_i))
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = phase_d;
      MODE_FLASH: led_d = wrap_d;
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q  <= '0;
      phase_q <= 1'b0;
      wrap_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      led_q   <= led_d;
    end
  end

  assign led_o  = led_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/multi_blink.sv
// multi_blink -- shared free-running prescaler driving NCH independent LED channels.
//   clk, rst : clock, async active-high reset
//   en       : prescaler advance enable
//   mode     : per-channel mode, channel i at [2i+1:2i]
//   div      : per-channel divide value, channel i at [DIVW*i +: DIVW]
//   led      : registered per-channel LED drive
//   flg      : registered prescaler tick flag (high the cycle after each wrap)
//   wrap     : registered per-channel divider-wrap pulse
module multi_blink
  import multi_blink_pkg::*;
#(
  parameter int CBITS = DEF_CBITS,
  parameter int NCH   = DEF_NCH,
  parameter int DIVW  = DEF_DIVW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2*NCH-1:0]    mode,
  input  logic [DIVW*NCH-1:0] div,
  output logic [NCH-1:0]      led,
  output logic                flg,
  output logic [NCH-1:0]      wrap
);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             flg_q;
  logic             tick;

  // Tick marks the edge on which the prescaler rolls over.
  assign tick  = en & (&cnt_q);
  assign cnt_d = en ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      flg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      flg_q <= tick;
    end
  end

  assign flg = flg_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    blink_chan #(.DIVW(DIVW)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .mode_i (mode[2*i +: 2]),
      .div_i  (div[DIVW*i +: DIVW]),
      .led_o  (led[i]),
      .wrap_o (wrap[i])
    );
  end

endmodule
